dma_copy_engine: RTL
====================

Name: dma_copy_engine

Overview:
Memory-side initiator that moves or fills blocks of 16-bit little-endian words in the shared 1 KiB byte-addressed data memory. It drives the memory's address, write-data and write-enable inputs, and reads the memory's combinational read port. It sits beside the pipeline's MEM stage and shares the memory port with it through a request/grant pair. Software (or a testbench) programs src/dst/len and pulses start.

Parameters:
ADDR_LIMIT, 16'h03FF, highest legal byte address; every accessed word must have both bytes at or below this address.
LEN_W, 10, width of the word-count input.

Ports:
clk        in   1      clock, rising edge
rst_n      in   1      synchronous active-low reset
start      in   1      begin operation; sampled only in IDLE
mode       in   1      0 = copy src->dst, 1 = fill dst with fill_data
src        in   16     source byte address (copy only; any alignment)
dst        in   16     destination byte address (any alignment)
len        in   LEN_W  number of 16-bit words
fill_data  in   16     fill pattern (mode 1)
abort      in   1      cancel the running operation
busy       out  1      high from the cycle after an accepted start until return to IDLE
done       out  1      1-cycle pulse after the last write of a completed operation
err        out  1      1-cycle pulse when start is rejected
words_left out  LEN_W  words not yet written
bus_req    out  1      engine wants the memory port
bus_gnt    in   1      port granted this cycle
mem_addr   out  16     byte address to memory
mem_wdata  out  16     write data, {hi,lo}
mem_we     out  1      memory write enable
mem_rdata  in   16     combinational read data for mem_addr

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; busy, done, err, bus_req, mem_we = 0; mem_addr, mem_wdata, words_left = 0; the buffer register is cleared.
- States: IDLE, RD, WR, FIN.
- IDLE + start:
  - Reject if len==0, or if the highest accessed byte (base + 2*len - 1) exceeds ADDR_LIMIT for dst, or for src in copy mode. Compute base + 2*len - 1 in 17 bits; no wrap allowed.
  - On reject: err pulses the next cycle and the engine stays IDLE.
  - Otherwise latch the parameters, set words_left = len, and go to RD (copy) or WR (fill).
- Direction: descending only when mode=0 and src < dst < src + 2*len (overlap with dst above src). Descending starts at base + 2*(len-1) and steps -2; ascending starts at base and steps +2. Both src and dst pointers step together.
- bus_req = 1 in RD and WR. An access happens only in a cycle with bus_gnt=1. Without a grant, the state and pointers hold.
- Bus outputs are driven only while bus_req is high; otherwise mem_addr = 0 and mem_we = 0.
- mem_we = (state==WR) & bus_gnt & ~abort. It is combinational; the memory commits at that posedge.
- RD with grant: mem_addr = src pointer; latch mem_rdata into the buffer; go to WR.
- WR with grant: mem_addr = dst pointer; mem_wdata = buffer (copy) or fill_data (fill); decrement words_left and advance the pointers.
  - If words_left was 1, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill).
- FIN: done = 1 for exactly this cycle, busy = 0, return to IDLE.
- Latency with bus_gnt held high:
  - copy: start accepted at cycle 0; writes occur on cycles 2, 4, …, 2*len; done on cycle 2*len+1.
  - fill: writes on cycles 1…len; done on cycle len+1.
- abort (any non-IDLE state) has priority over everything:
  - No write occurs in that cycle.
  - Next cycle: IDLE, busy = 0, no done, no err; words_left keeps its value.
- start while busy is ignored. start and abort together in IDLE: start wins (abort has no effect in IDLE).
- Reset mid-operation: immediate IDLE with reset values; a partially copied block is not rolled back.

Decomposition:
- Shared package dma_pkg: state encoding enum (IDLE/RD/WR/FIN), mode constants MODE_COPY/MODE_FILL, default ADDR_LIMIT.
- One natural sub-module, dma_range_check: combinational start validation and direction decision. Inputs: src, dst, len, mode. Outputs: ok, descending.

Test Plan:
- Copy ascending: mem[0x100..0x105] = 11 22 33 44 55 66; src=0x100, dst=0x200, len=3, gnt=1 -> bytes at 0x200 = 11 22 33 44 55 66; done at cycle 7; 3 writes, each 2 cycles apart.
- Overlapping descending: bytes 0x10..0x13 = A1 B2 C3 D4; src=0x10, dst=0x11, len=2 -> bytes 0x11..0x14 = A1 B2 C3 D4, byte 0x10 still A1; first write address 0x13.
- Fill with stalled grant: dst=0x300, len=4, fill_data=0xBEEF, gnt toggles 1,0,1,0… -> words at 0x300/302/304/306 = 0xBEEF (bytes EF BE); mem_we never high when gnt=0; done after the 4th granted write.
- Rejects: len=0 -> err pulse, busy stays 0; dst=0x3FE, len=1 accepted (highest byte 0x3FF); dst=0x3FF, len=1 -> err; copy with src=0x3F0, len=9 -> err.
- Abort: copy len=8, abort on the 3rd WR cycle -> exactly 2 words written, no write that cycle, busy low next cycle, no done, words_left=6.
- Reset mid-fill: rst_n=0 during WR -> next cycle all outputs 0; a new start after reset completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA copy/fill engine: FSM state encoding,
// operating-mode constants and the default address limit of the 1 KiB
// byte-addressed data memory.
// ---------------------------------------------------------------------------
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam logic [15:0] DMA_ADDR_LIMIT = 16'h03FF;
    localparam int          DMA_LEN_W      = 10;

endpackage

// File: rtl/dma_copy_engine_if.sv
// ---------------------------------------------------------------------------
// dma_copy_engine_if
// Memory-port bundle shared between the DMA engine and the data memory /
// port arbiter.
//   bus_req   engine requests the memory port
//   bus_gnt   port granted this cycle
//   mem_addr  byte address to memory
//   mem_wdata write data {hi,lo}
//   mem_we    write enable (memory commits at the rising edge)
//   mem_rdata combinational read data for mem_addr
// master = engine side, slave = memory/arbiter side.
// ---------------------------------------------------------------------------
interface dma_copy_engine_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    modport master (
        output bus_req, mem_addr, mem_wdata, mem_we,
        input  bus_gnt, mem_rdata
    );

    modport slave (
        input  bus_req, mem_addr, mem_wdata, mem_we,
        output bus_gnt, mem_rdata
    );
endinterface

// File: rtl/dma_range_check.sv
// ---------------------------------------------------------------------------
// dma_range_check
// Combinational start validation and transfer-direction decision.
//   src, dst    base byte addresses (any alignment)
//   len         word count
//   mode        MODE_COPY / MODE_FILL
//   ok          request is legal (non-zero length, every touched byte of dst,
//               and of src when copying, lies at or below ADDR_LIMIT)
//   descending  copy must run from the top down because dst overlaps src
//               from above
// ---------------------------------------------------------------------------
module dma_range_check
    import dma_pkg::*;
#(
    parameter logic [15:0] ADDR_LIMIT = DMA_ADDR_LIMIT,
    parameter int          LEN_W      = DMA_LEN_W
) (
    input  logic [15:0]      src,
    input  logic [15:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             mode,
    output logic             ok,
    output logic             descending
);

    logic [16:0] span;
    logic [16:0] src_end;
    logic [16:0] dst_end;
    logic [16:0] limit;

    // Byte span 2*len and end addresses are kept in 17 bits so an end
    // address past 0xFFFF is seen as out of range instead of wrapping.
    assign span    = {{(16-LEN_W){1'b0}}, len, 1'b0};
    assign src_end = {1'b0, src} + span - 17'd1;
    assign dst_end = {1'b0, dst} + span - 17'd1;
    assign limit   = {1'b0, ADDR_LIMIT};

    assign ok = (len != '0) && (dst_end <= limit) &&
                ((mode == MODE_FILL) || (src_end <= limit));

    assign descending = (mode == MODE_COPY) &&
                        ({1'b0, src} < {1'b0, dst}) &&
                        ({1'b0, dst} < ({1'b0, src} + span));

endmodule

// File: rtl/dma_copy_engine.sv
// ---------------------------------------------------------------------------
// dma_copy_engine
// Memory-side initiator that copies or fills blocks of 16-bit little-endian
// words in the shared data memory, sharing the port via bus_req/bus_gnt.
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin operation (sampled in IDLE only)
//   mode         0 copy src->dst, 1 fill dst with fill_data
//   src,dst,len  source/destination byte addresses, word count
//   fill_data    fill pattern
//   abort        cancel running operation (highest priority)
//   busy         operation in progress (RD/WR)
//   done         one-cycle pulse after the final write
//   err          one-cycle pulse when start is rejected
//   words_left   words not yet written
//   bus          memory port (master modport)
// ---------------------------------------------------------------------------
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter logic [15:0] ADDR_LIMIT = DMA_ADDR_LIMIT,
    parameter int          LEN_W      = DMA_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      src,
    input  logic [15:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      fill_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_left,
    dma_copy_engine_if.master bus
);

    dma_state_e       state_q, state_d;
    logic [15:0]      src_q, src_d;
    logic [15:0]      dst_q, dst_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic [15:0]      buf_q, buf_d;
    logic [15:0]      fill_q, fill_d;
    logic             mode_q, mode_d;
    logic             desc_q, desc_d;
    logic             err_q, err_d;

    logic             start_ok;
    logic             start_desc;
    logic [15:0]      last_off;

    dma_range_check #(
        .ADDR_LIMIT (ADDR_LIMIT),
        .LEN_W      (LEN_W)
    ) u_range (
        .src        (src),
        .dst        (dst),
        .len        (len),
        .mode       (mode),
        .ok         (start_ok),
        .descending (start_desc)
    );

    // Offset of the last word, 2*(len-1); only used once len is known non-zero.
    assign last_off = {{(15-LEN_W){1'b0}}, len, 1'b0} - 16'd2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            words_left_q <= '0;
            buf_q        <= '0;
            fill_q       <= '0;
            mode_q       <= MODE_COPY;
            desc_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            words_left_q <= words_left_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            mode_q       <= mode_d;
            desc_q       <= desc_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        words_left_d  = words_left_q;
        buf_d         = buf_q;
        fill_d        = fill_q;
        mode_d        = mode_q;
        desc_d        = desc_q;
        err_d         = 1'b0;
        bus.bus_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!start_ok) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d       = mode;
                        desc_d       = start_desc;
                        fill_d       = fill_data;
                        words_left_d = len;
                        src_d        = start_desc ? (src + last_off) : src;
                        dst_d        = start_desc ? (dst + last_off) : dst;
                        state_d      = (mode == MODE_COPY) ? RD : WR;
                    end
                end
            end
            RD: begin
                bus.bus_req  = 1'b1;
                bus.mem_addr = src_q;
                if (bus.bus_gnt) begin
                    buf_d   = bus.mem_rdata;
                    state_d = WR;
                end
            end
            WR: begin
                bus.bus_req   = 1'b1;
                bus.mem_addr  = dst_q;
                bus.mem_wdata = (mode_q == MODE_FILL) ? fill_q : buf_q;
                bus.mem_we    = bus.bus_gnt;
                if (bus.bus_gnt) begin
                    words_left_d = words_left_q - LEN_W'(1);
                    src_d        = desc_q ? (src_q - 16'd2) : (src_q + 16'd2);
                    dst_d        = desc_q ? (dst_q - 16'd2) : (dst_q + 16'd2);
                    if (words_left_q == LEN_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = (mode_q == MODE_COPY) ? RD : WR;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE: no write, progress frozen.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            bus.mem_we   = 1'b0;
            src_d        = src_q;
            dst_d        = dst_q;
            words_left_d = words_left_q;
            buf_d        = buf_q;
        end
    end

    assign busy       = (state_q == RD) || (state_q == WR);
    assign done       = (state_q == FIN);
    assign err        = err_q;
    assign words_left = words_left_q;

endmodule
